// File: rtl/xor_arb_pkg.sv
// Shared constants, id-width helper and stage bundle for the XOR-sharing arbiter.
// Imported by the arbiter and the top level.
package xor_arb_pkg;

    localparam int N_DEF   = 4;
    localparam int W_DEF   = 8;
    localparam int LAT_DEF = 2;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int IDW_DEF = id_width(N_DEF);

    typedef struct packed {
        logic               valid;
        logic [W_DEF-1:0]   data;
        logic [IDW_DEF-1:0] id;
    } xor_stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr, modulo N.
// The pointer register lives in the caller.
module rr_arbiter
    import xor_arb_pkg::*;
#(
    parameter  int N   = N_DEF,
    localparam int IDW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any    = 1'b1;
                gnt_id = IDW'((int'(ptr) + k) % N);
            end
        end
        gnt[gnt_id] = any;
    end

endmodule

// File: rtl/xor_share_arb.sv
// Round-robin sharing of one XOR unit among N requesters through a
// stallable LAT-stage pipeline with a tagged response port.
module xor_share_arb
    import xor_arb_pkg::*;
#(
    parameter  int N   = N_DEF,
    parameter  int W   = W_DEF,
    parameter  int LAT = LAT_DEF,
    localparam int IDW = id_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic [IDW-1:0] rsp_id,
    output logic           busy
);

    typedef struct packed {
        logic           valid;
        logic [W-1:0]   data;
        logic [IDW-1:0] id;
    } stage_t;

    stage_t         stage_q [LAT];
    stage_t         stage0_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           any;
    logic           adv;

    rr_arbiter #(.N(N)) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    assign adv       = !stage_q[LAT-1].valid || rsp_ready;
    // rst_n gates the grant so nothing is offered while held in reset
    assign req_ready = gnt & {N{adv && rst_n}};

    always_comb begin
        ptr_d          = ptr_q;
        stage0_d.valid = any;
        stage0_d.data  = req_a[int'(gnt_id)*W +: W]
                       ^ req_b[int'(gnt_id)*W +: W];
        stage0_d.id    = gnt_id;
        if (adv && any) begin
            ptr_d = (int'(gnt_id) == N-1) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            if (adv) begin
                stage_q[0] <= stage0_d;
                for (int i = 1; i < LAT; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | stage_q[i].valid;
        end
    end

    assign rsp_valid = stage_q[LAT-1].valid;
    assign rsp_data  = stage_q[LAT-1].data;
    assign rsp_id    = stage_q[LAT-1].id;

endmodule
